// File: rtl/fir_mac_sequencer_if.sv
// Sample input, result handshake, coefficient configuration and status
// signals of fir_mac_sequencer.
interface fir_mac_sequencer_if #(
  parameter int DATA_W = 10,
  parameter int COEF_W = 16,
  parameter int NTAPS  = 31
);
  localparam int H  = (NTAPS + 1) / 2;
  localparam int AW = $clog2(H);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [COEF_W-1:0] cfg_data;
  logic              busy;
  logic              overrun;
  logic              cfg_err;

  modport master (
    output in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
    input  out_valid, out_data, busy, overrun, cfg_err
  );

  modport slave (
    input  in_valid, in_data, out_ready, cfg_we, cfg_addr, cfg_data,
    output out_valid, out_data, busy, overrun, cfg_err
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Symmetric odd-length FIR with one shared multiplier: folds tap pairs,
// accumulates one pair per cycle, then rounds/saturates to DATA_W bits.
module fir_mac_sequencer #(
  parameter int DATA_W = 10,
  parameter int COEF_W = 16,
  parameter int NTAPS  = 31
) (
  input logic               clk,
  input logic               reset,
  fir_mac_sequencer_if.slave bus
);
  localparam int H     = (NTAPS + 1) / 2;
  localparam int AW    = $clog2(H);
  localparam int PW    = $clog2(NTAPS);
  localparam int PRW   = COEF_W + DATA_W + 1;
  localparam int ACC_W = DATA_W + 1 + COEF_W + AW + 1;
  localparam int RW    = ACC_W - COEF_W;

  localparam logic [PW-1:0]    PTR_LAST = PW'(NTAPS - 1);
  localparam logic [AW-1:0]    K_LAST   = AW'(H - 1);
  localparam logic [PW:0]      NT_EXT   = (PW + 1)'(NTAPS);
  localparam logic [ACC_W-1:0] RND      = ACC_W'(1) << (COEF_W - 1);

  typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] hist [NTAPS];
  logic [COEF_W-1:0] coef [H];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     head_q;
  logic [AW-1:0]     k_q;
  logic [ACC_W-1:0]  acc_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              overrun_q;
  logic              cfg_err_q;

  logic accept, mac_step, do_round, out_release;
  logic addr_ok, cfg_ok;

  logic [PW:0]       a_sum, b_sum, idx_a, idx_b;
  logic [DATA_W-1:0] xa, xb;
  logic [DATA_W:0]   pair;
  logic [PRW-1:0]    prod;
  logic [ACC_W-1:0]  rnd_sum;
  logic [RW-1:0]     rnd_q;
  logic [DATA_W-1:0] sat_q;

  if (H == (1 << AW)) begin : g_addr_full
    assign addr_ok = 1'b1;
  end else begin : g_addr_range
    assign addr_ok = (bus.cfg_addr < AW'(H));
  end

  assign cfg_ok = bus.cfg_we && (state_q == IDLE) && addr_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    mac_step    = 1'b0;
    do_round    = 1'b0;
    out_release = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        mac_step = 1'b1;
        if (k_q == K_LAST) state_d = ROUND;
      end
      ROUND: begin
        do_round = 1'b1;
        state_d  = OUT;
      end
      OUT: begin
        if (bus.out_ready) begin
          out_release = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // head_q holds x[n]; x[n-k] sits k slots behind it and x[n-(NTAPS-1-k)]
  // sits k+1 slots ahead of it in the circular history.
  always_comb begin
    a_sum = {1'b0, head_q} + NT_EXT - (PW + 1)'(k_q);
    b_sum = {1'b0, head_q} + (PW + 1)'(k_q) + (PW + 1)'(1);
    idx_a = (a_sum >= NT_EXT) ? a_sum - NT_EXT : a_sum;
    idx_b = (b_sum >= NT_EXT) ? b_sum - NT_EXT : b_sum;
    xa    = hist[idx_a[PW-1:0]];
    xb    = hist[idx_b[PW-1:0]];
    pair  = (k_q == K_LAST) ? {1'b0, xa} : ({1'b0, xa} + {1'b0, xb});
    prod  = PRW'(coef[k_q]) * PRW'(pair);
  end

  always_comb begin
    rnd_sum = acc_q + RND;
    rnd_q   = rnd_sum[ACC_W-1:COEF_W];
    sat_q   = (|rnd_q[RW-1:DATA_W]) ? '1 : rnd_q[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < H; i++) coef[i] <= '0;
      coef[H-1] <= '1;
    end else if (cfg_ok) begin
      coef[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NTAPS; i++) hist[i] <= '0;
      wr_ptr_q    <= '0;
      head_q      <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        hist[wr_ptr_q] <= bus.in_data;
        head_q         <= wr_ptr_q;
        wr_ptr_q       <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
        acc_q          <= '0;
        k_q            <= '0;
      end
      if (mac_step) begin
        acc_q <= acc_q + ACC_W'(prod);
        k_q   <= (k_q == K_LAST) ? '0 : k_q + AW'(1);
      end
      if (do_round) begin
        out_data_q  <= sat_q;
        out_valid_q <= 1'b1;
      end
      if (out_release) out_valid_q <= 1'b0;
      if (bus.in_valid && (state_q != IDLE)) overrun_q <= 1'b1;
      if (bus.cfg_we && !cfg_ok) cfg_err_q <= 1'b1;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.overrun   = overrun_q;
  assign bus.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: direct-form FIR transaction model checked every
// cycle, directed literal cases, then randomized traffic.
module tb_fir_mac_sequencer;
  localparam int DW  = 10;
  localparam int CW  = 16;
  localparam int NT  = 31;
  localparam int HH  = (NT + 1) / 2;
  localparam int AWB = $clog2(HH);

  logic clk;
  logic reset;
  bit   mon_en = 0;
  int   checks = 0;
  int   errors = 0;

  fir_mac_sequencer_if #(.DATA_W(DW), .COEF_W(CW), .NTAPS(NT)) bus ();

  fir_mac_sequencer #(.DATA_W(DW), .COEF_W(CW), .NTAPS(NT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: newest sample at hist_m[0], full direct-form sum.
  longint coef_m [HH];
  longint hist_m [NT];
  bit     m_busy = 0, m_valid = 0, m_ovr = 0, m_cerr = 0;
  int     m_cnt = 0;
  longint m_exp = 0, m_data = 0;

  function automatic longint fir_out();
    longint sum = 0;
    longint r;
    for (int j = 0; j < NT; j++) sum += coef_m[(j < HH) ? j : NT - 1 - j] * hist_m[j];
    r = (sum + (longint'(1) << (CW - 1))) >>> CW;
    if (r > (longint'(1) << DW) - 1) r = (longint'(1) << DW) - 1;
    return r;
  endfunction

  task automatic model_step();
    if (reset) begin
      for (int i = 0; i < HH; i++) coef_m[i] = 0;
      coef_m[HH-1] = (longint'(1) << CW) - 1;
      for (int i = 0; i < NT; i++) hist_m[i] = 0;
      m_busy = 0; m_valid = 0; m_ovr = 0; m_cerr = 0; m_cnt = 0; m_exp = 0; m_data = 0;
    end else if (!m_busy) begin
      if (bus.cfg_we) begin
        if (int'(bus.cfg_addr) < HH) coef_m[bus.cfg_addr] = longint'(bus.cfg_data);
        else m_cerr = 1;
      end
      if (bus.in_valid) begin
        for (int i = NT - 1; i > 0; i--) hist_m[i] = hist_m[i-1];
        hist_m[0] = longint'(bus.in_data);
        m_exp  = fir_out();
        m_busy = 1;
        m_cnt  = 0;
      end
    end else begin
      if (bus.in_valid) m_ovr = 1;
      if (bus.cfg_we) m_cerr = 1;
      if (m_valid) begin
        if (bus.out_ready) begin
          m_valid = 0;
          m_busy  = 0;
        end
      end else begin
        m_cnt++;
        if (m_cnt == HH + 1) begin
          m_valid = 1;
          m_data  = m_exp;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (mon_en && !reset) begin
      check("out_valid", bus.out_valid, m_valid);
      check("out_data",  bus.out_data,  m_data);
      check("busy",      bus.busy,      m_busy);
      check("overrun",   bus.overrun,   m_ovr);
      check("cfg_err",   bus.cfg_err,   m_cerr);
    end
  end

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.cfg_we   = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 100) check("out_valid_timeout", 0, 1);
  endtask

  task automatic send(input int s, output int r, output int lat);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(s);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_valid(lat);
    r = int'(bus.out_data);
    @(negedge clk);
  endtask

  task automatic cfg_write(input int a, input int d);
    @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = AWB'(a);
    bus.cfg_data = CW'(d);
    @(negedge clk);
    bus.cfg_we   = 1'b0;
  endtask

  initial begin
    int r, lat, cnt, first;
    reset = 1'b1;
    bus.out_ready = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    mon_en = 1;
    check("rst_busy", bus.busy, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_cfg_err", bus.cfg_err, 0);

    for (int i = 1; i <= 20; i++) begin
      send(i, r, lat);
      check("passthru", r, (i >= 16) ? i - 15 : 0);
      check("latency", lat, 17);
    end

    for (int k = 0; k < HH; k++) cfg_write(k, 2048);
    for (int i = 1; i <= 32; i++) begin
      send(1000, r, lat);
      if (i >= 31) check("coef2048_1000", r, 969);
    end

    for (int k = 0; k < HH; k++) cfg_write(k, 65535);
    for (int i = 1; i <= 31; i++) begin
      send(1023, r, lat);
      if (i == 31) check("saturate_1023", r, 1023);
    end

    do_reset();
    check("overrun_before", bus.overrun, 0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(111);
    @(negedge clk);
    bus.in_data  = DW'(222);
    @(negedge clk);
    bus.in_valid = 1'b0;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.out_valid && bus.out_ready) cnt++;
      @(negedge clk);
    end
    check("single_result", cnt, 1);
    check("overrun_b2b", bus.overrun, 1);

    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(77);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_valid(lat);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      bus.in_valid = (c == 10);
      check("hold_valid", bus.out_valid, 1);
      check("hold_busy", bus.busy, 1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("release_busy", bus.busy, 0);
    check("release_valid", bus.out_valid, 0);

    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(300);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = '0;
    bus.cfg_data = '1;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    check("cfg_err_mac", bus.cfg_err, 1);
    wait_valid(lat);
    @(negedge clk);
    for (int i = 0; i < 30; i++) send(int'($urandom_range(1, 1023)), r, lat);

    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(500);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midmac_rst_valid", bus.out_valid, 0);
    check("midmac_rst_busy", bus.busy, 0);
    check("midmac_rst_cfg_err", bus.cfg_err, 0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    first = int'($urandom_range(1, 1023));
    for (int i = 1; i <= 16; i++) begin
      send((i == 1) ? first : int'($urandom_range(1, 1023)), r, lat);
      check("fresh_passthru", r, (i == 16) ? first : 0);
    end

    @(negedge clk);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = AWB'(HH - 1);
    bus.cfg_data = '0;
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(700);
    @(negedge clk);
    idle_inputs();
    wait_valid(lat);
    check("cfg_same_cycle", bus.out_data, 0);
    @(negedge clk);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.in_valid  = ($urandom_range(0, 5) == 0);
      bus.in_data   = DW'($urandom);
      bus.cfg_we    = ($urandom_range(0, 11) == 0);
      bus.cfg_addr  = AWB'($urandom);
      bus.cfg_data  = ($urandom_range(0, 3) == 0) ? CW'($urandom) : CW'($urandom_range(0, 4095));
      bus.out_ready = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    idle_inputs();
    bus.out_ready = 1'b1;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fir_mac_sequencer.md
FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 Parameter DATA_W, 10, sample width (unsigned), SHALL be honoured by all sample/output ports.
REQ-002 Parameter COEF_W, 16, coefficient width; unsigned Q0.COEF_W (value = c / 2^COEF_W).
REQ-003 Parameter NTAPS, 31, filter length; odd, >= 3; H = (NTAPS+1)/2 unique symmetric coefficients.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high.
REQ-006 in_valid  input  1  one-cycle strobe; new sample on in_data.
REQ-007 in_data  input  DATA_W  new sample.
REQ-008 out_valid  output  1  filtered result available.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 out_data  output  DATA_W  filtered, rounded, saturated result.
REQ-011 cfg_we  input  1  coefficient write strobe.
REQ-012 cfg_addr  input  clog2(H)  coefficient index k (0 = outer tap pair, H-1 = centre tap).
REQ-013 cfg_data  input  COEF_W  coefficient value.
REQ-014 busy  output  1  high whenever state != IDLE.
REQ-015 overrun  output  1  sticky: a sample was dropped.
REQ-016 cfg_err  output  1  sticky: a coefficient write was rejected.

Function
REQ-017 Single shared multiplier; FSM states IDLE, MAC, ROUND, OUT.
REQ-018 IDLE + in_valid: write in_data into NTAPS-entry circular history at wr_ptr, wr_ptr advances mod NTAPS (NTAPS-1 -> 0), acc cleared, k = 0, go MAC.
REQ-019 MAC: one step per cycle, k = 0..H-1; k < H-1: acc += coef[k] * (x[n-k] + x[n-(NTAPS-1-k)]); k = H-1: acc += coef[k] * x[n-k]; x[n] = newest sample.
REQ-020 Pair sum DATA_W+1 bits; acc wide enough never to overflow (>= DATA_W+1+COEF_W+clog2(H) bits).
REQ-021 After step H-1 go ROUND; ROUND computes (acc + 2^(COEF_W-1)) >> COEF_W, saturates to 2^DATA_W-1, registers out_data, sets out_valid, go OUT.
REQ-022 Latency: out_valid rises H+1 rising edges after the accepting edge (17 for defaults).
REQ-023 OUT: out_valid and out_data held stable until out_valid && out_ready at a rising edge; then out_valid low, state IDLE.
REQ-024 in_valid only accepted in IDLE; in_valid in MAC/ROUND/OUT: sample dropped, history unchanged, overrun set.
REQ-025 cfg_we in IDLE with cfg_addr < H: coef[cfg_addr] <= cfg_data at that edge.
REQ-026 cfg_we in IDLE with cfg_addr >= H: ignored, cfg_err set; cfg_we outside IDLE: ignored, cfg_err set.
REQ-027 cfg_we and in_valid same IDLE cycle: both take effect; the MAC for that sample uses the new coefficient.
REQ-028 overrun and cfg_err clear only on reset.

Reset
REQ-029 reset asserted (any state, including mid-MAC): state IDLE, out_valid 0, out_data 0, busy 0, overrun 0, cfg_err 0, acc 0, k 0, wr_ptr 0, all history entries 0, effective immediately (asynchronous).
REQ-030 Coefficients on reset: coef[H-1] = 2^COEF_W-1, all others 0 (exact pass-through delayed by H-1 samples).

Verification
REQ-031 After reset, out_ready=1, feed samples 1..20 spaced >= H+3 cycles -> outputs 0 for first 15 samples, then 1,2,3,4,5; each out_valid 17 edges after accept.
REQ-032 Write all 16 coefs = 2048, feed 31+ samples of 1000 -> steady out_data = 969.
REQ-033 All coefs = 65535, constant input 1023 -> out_data = 1023 (saturated), no wrap.
REQ-034 in_valid on two consecutive cycles from IDLE -> first accepted, second dropped, overrun = 1, exactly one out_valid.
REQ-035 out_ready=0 for 50 cycles after out_valid -> out_valid/out_data held, busy=1, in_valid during hold sets overrun; out_ready=1 -> IDLE next cycle, busy=0.
REQ-036 cfg_we during MAC -> coefficient unchanged, cfg_err = 1; reset asserted mid-MAC -> out_valid 0, next result after reset equals pass-through of fresh samples.
